uart_tx: RTL and testbench

UART transmitter that is the PC-bound counterpart of uart_rx. It accepts bytes from the sensor side over a valid/ready handshake and buffers them in a small FIFO. It serializes each byte as 8N1 frames on tx_sig at BAUD_RATE. The block sits between the sensor datapath and the board's UART TX pin.

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and a valid/ready write side.
// tx_sig comes straight from a flop and idles high.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] sensor_data,
  input  logic                  sensor_valid,
  output logic                  sensor_ready,
  output logic                  tx_sig,
  output logic                  tx_busy
);

  localparam int unsigned PulseWidth = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (PulseWidth > 1) ? $clog2(PulseWidth) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CntW-1:0] LastCnt   = CntW'(PulseWidth - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(DATA_WIDTH - 1);
  localparam logic [PtrW:0]   FullCount = FIFO_DEPTH[PtrW:0];

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, bit_end;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FullCount);
  assign sensor_ready = !fifo_full;
  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign push         = sensor_valid && !fifo_full;
  assign tx_sig       = tx_q;
  assign tx_busy      = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bit_end = (cnt_q == LastCnt);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IdxW'(1);
            tx_d    = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sensor_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-shape vectors, back-to-back, FIFO-full, reset mid-frame,
// plus a line sampler that decodes every frame it sees on tx_sig.
module tb_uart_tx;

  localparam int unsigned PW = 16;  // 1_600_000 / 100_000

  logic       clk;
  logic       rstn;
  logic [7:0] sensor_data;
  logic       sensor_valid;
  logic       sensor_ready;
  logic       tx_sig;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the line (start first)
  } vec_t;
  vec_t vec [4];

  uart_tx #(
    .DATA_WIDTH(8),
    .BAUD_RATE (100_000),
    .CLK_FREQ  (1_600_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sensor_data (sensor_data),
    .sensor_valid(sensor_valid),
    .sensor_ready(sensor_ready),
    .tx_sig      (tx_sig),
    .tx_busy     (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    sensor_data  = d;
    sensor_valid = 1'b1;
    @(posedge clk);
    #1;
    sensor_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (tx_busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, tx_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Line sampler: mid-bit sampling, abandons a frame if reset is seen.
  initial begin : monitor
    int         off;
    logic [9:0] fr;
    bit         ok;
    int         t0;
    forever begin
      @(negedge clk);
      if (rstn && tx_sig === 1'b0) begin
        ok  = 1'b1;
        off = 0;
        fr  = '0;
        t0  = cyc;
        while (ok && off < 9 * PW + PW / 2) begin
          if (off % PW == PW / 2) fr[off/PW] = tx_sig;
          @(negedge clk);
          off++;
          if (!rstn) ok = 1'b0;
        end
        if (ok) begin
          fr[9] = tx_sig;
          check("mon start bit", {31'd0, fr[0]}, 32'd0);
          check("mon stop bit", {31'd0, fr[9]}, 32'd1);
          rx_q.push_back(fr[8:1]);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin : main
    int   acc;
    logic r;
    bit   bad;

    vec[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    vec[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    vec[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    vec[3] = '{data: 8'h55, frame: 10'b1_0101_0101_0};

    rstn         = 1'b1;
    sensor_valid = 1'b0;
    sensor_data  = 8'h00;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_sig", {31'd0, tx_sig}, 32'd1);
    check("reset sensor_ready", {31'd0, sensor_ready}, 32'd1);
    check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle tx_sig", {31'd0, tx_sig}, 32'd1);

    // Single frames with exact per-bit timing.
    for (int v = 0; v < 4; v++) begin
      send(vec[v].data);
      check($sformatf("v%0d tx high on accept edge", v), {31'd0, tx_sig}, 32'd1);
      check($sformatf("v%0d busy after accept", v), {31'd0, tx_busy}, 32'd1);
      @(posedge clk);
      #1;
      for (int b = 0; b < 10; b++) begin
        check($sformatf("v%0d bit%0d first", v, b), {31'd0, tx_sig}, {31'd0, vec[v].frame[b]});
        repeat (PW - 1) @(posedge clk);
        #1;
        check($sformatf("v%0d bit%0d last", v, b), {31'd0, tx_sig}, {31'd0, vec[v].frame[b]});
        if (b == 9) check($sformatf("v%0d busy in stop", v), {31'd0, tx_busy}, 32'd1);
        @(posedge clk);
        #1;
      end
      check($sformatf("v%0d busy after stop", v), {31'd0, tx_busy}, 32'd0);
      check($sformatf("v%0d tx idle after stop", v), {31'd0, tx_sig}, 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("table rx count", rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check($sformatf("table rx byte %0d", i), {24'd0, rx_q[i]}, {24'd0, vec[i].data});

    // Back-to-back frames.
    rx_q.delete();
    rx_t.delete();
    send(8'h5A);
    send(8'hFF);
    wait_idle(40 * PW, "b2b idle");
    check("b2b rx count", rx_q.size(), 32'd2);
    if (rx_q.size() == 2) begin
      check("b2b byte0", {24'd0, rx_q[0]}, 32'h5A);
      check("b2b byte1", {24'd0, rx_q[1]}, 32'hFF);
      check("b2b start gap", rx_t[1] - rx_t[0], 10 * PW);
    end

    // FIFO full, valid without ready, ready return after the STOP->START pop.
    rx_q.delete();
    rx_t.delete();
    sensor_data  = 8'h01;
    sensor_valid = 1'b1;
    acc          = 0;
    repeat (12) begin
      @(negedge clk);
      r = sensor_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        sensor_data = sensor_data + 8'h01;
      end
    end
    check("full handshakes", acc, 32'd5);
    check("full ready low", {31'd0, sensor_ready}, 32'd0);
    sensor_data = 8'hC3;
    repeat (30) @(posedge clk);
    #1;
    check("ready low while C3 held", {31'd0, sensor_ready}, 32'd0);
    sensor_valid = 1'b0;
    repeat (10 * PW - 41) @(posedge clk);
    #1;
    check("ready before pop", {31'd0, sensor_ready}, 32'd0);
    sensor_data  = 8'h06;
    sensor_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready after pop", {31'd0, sensor_ready}, 32'd1);
    @(posedge clk);
    #1;
    sensor_valid = 1'b0;
    wait_idle(100 * PW, "full idle");
    check("full rx count", rx_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < rx_q.size()) check($sformatf("full rx byte %0d", i), {24'd0, rx_q[i]}, i + 1);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    rx_q.delete();
    rx_t.delete();
    send(8'h3C);
    send(8'h11);
    send(8'h22);
    repeat (71) @(posedge clk);
    #1;
    check("pre-reset data bit3", {31'd0, tx_sig}, 32'd1);
    check("pre-reset busy", {31'd0, tx_busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid reset tx_sig", {31'd0, tx_sig}, 32'd1);
    check("mid reset ready", {31'd0, sensor_ready}, 32'd1);
    check("mid reset busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    bad  = 1'b0;
    repeat (30 * PW) begin
      @(negedge clk);
      if (tx_sig !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    check("idle after reset", {31'd0, bad}, 32'd0);
    check("no frame after reset", rx_q.size(), 32'd0);
    @(posedge clk);
    #1;
    send(8'h81);
    wait_idle(20 * PW, "post-reset idle");
    check("post-reset rx count", rx_q.size(), 32'd1);
    if (rx_q.size() == 1) check("post-reset byte", {24'd0, rx_q[0]}, 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
